// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed digit scanner with frame-aligned double buffering.
// Optional: DIGIT_SCAN_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module digit_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_DIGITS*DATA_W-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  input  logic                           load,
  output logic                           pending,
  output logic [DATA_W-1:0]              Y,
  output logic [$clog2(NUM_DIGITS)-1:0]  sel,
  output logic [NUM_DIGITS-1:0]          anode_n,
  output logic                           frame_done
);

  localparam int SW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = NUM_DIGITS * DATA_W;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [BW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
  logic                  pend_q, pend_d;
  logic [BW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
  logic [DATA_W-1:0]     y_q, y_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  fdone_q;

  logic                  tick;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] lit;

  assign tick = (presc_q == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (sel_q == SW'(NUM_DIGITS - 1));

  // Prescaler and digit-select advance
  always_comb begin
    presc_d = presc_q + 1'b1;
    sel_d   = sel_q;
    if (tick) begin
      presc_d = '0;
      sel_d   = wrap ? '0 : sel_q + 1'b1;
    end
  end

  // Bank update: a wrap-tick load bypasses straight to the active bank
  always_comb begin
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pend_d      = pend_q;
    act_data_d  = act_data_q;
    act_en_d    = act_en_q;
    if (wrap && load) begin
      act_data_d = data_in;
      act_en_d   = digit_en;
      pend_d     = 1'b0;
    end else if (wrap && pend_q) begin
      act_data_d = pend_data_q;
      act_en_d   = pend_en_q;
      pend_d     = 1'b0;
    end else if (load) begin
      pend_data_d = data_in;
      pend_en_d   = digit_en;
      pend_d      = 1'b1;
    end
  end

  // Blank mask: digits above the most significant non-zero one
  always_comb begin
    blank = '0;
`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
    begin : lzb
      logic zero_above;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        zero_above = zero_above &
          (act_data_q[i*DATA_W +: DATA_W] == '0);
        blank[i] = zero_above;
      end
    end
`endif
  end

  // Digit value mux and strobe, with dead time after each tick
  always_comb begin
    y_d = '0;
    lit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q == SW'(i)) begin
        y_d    = act_data_q[i*DATA_W +: DATA_W];
        lit[i] = act_en_q[i] & ~blank[i];
      end
    end
    anode_d = tick ? '1 : ~lit;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      sel_q       <= '0;
      pend_data_q <= '0;
      pend_en_q   <= '0;
      pend_q      <= 1'b0;
      act_data_q  <= '0;
      act_en_q    <= '0;
      y_q         <= '0;
      anode_q     <= '1;
      fdone_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sel_q       <= sel_d;
      pend_data_q <= pend_data_d;
      pend_en_q   <= pend_en_d;
      pend_q      <= pend_d;
      act_data_q  <= act_data_d;
      act_en_q    <= act_en_d;
      y_q         <= y_d;
      anode_q     <= anode_d;
      fdone_q     <= wrap;
    end
  end

  assign pending    = pend_q;
  assign Y          = y_q;
  assign sel        = sel_q;
  assign anode_n    = anode_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed self-checking bench for digit_scan_mux.
// Runs with NUM_DIGITS=8, DATA_W=4, REFRESH_DIV=4.
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [7:0]  digit_en;
  logic        load;
  logic        pending;
  logic [3:0]  Y;
  logic [2:0]  sel;
  logic [7:0]  anode_n;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int kk       = 0;
  logic [7:0] lz_en;

  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS (8),
    .DATA_W     (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .digit_en  (digit_en),
    .load      (load),
    .pending   (pending),
    .Y         (Y),
    .sel       (sel),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, kk, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    kk++;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e);
    data_in  = d;
    digit_en = e;
    load     = 1'b1;
    adv();
    load     = 1'b0;
  endtask

  // Advance to cycle k_end, checking every cycle against the
  // expected active bank contents d / effective lit mask e.
  task automatic check_range(input int k_end, input logic [31:0] d,
                             input logic [7:0] e);
    int s;
    logic [31:0] sh;
    logic [7:0] exp_an;
    while (kk < k_end) begin
      adv();
      s = (kk / 4) % 8;
      chk("sel", {29'b0, sel}, s);
      chk("frame_done", {31'b0, frame_done}, (kk % 32) == 0);
      if ((kk % 4) == 0) begin
        chk("anode_dead", {24'b0, anode_n}, 32'hFF);
      end else begin
        exp_an = e[s] ? ~(8'b1 << s) : 8'hFF;
        chk("anode_lit", {24'b0, anode_n}, {24'b0, exp_an});
        sh = d >> (4 * s);
        chk("Y", {28'b0, Y}, {28'b0, sh[3:0]});
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    data_in  = '0;
    digit_en = '0;
    load     = 1'b0;
`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
    lz_en = 8'h07;
`else
    lz_en = 8'h0F;
`endif
    repeat (3) @(negedge clk);
    chk("rst_anode", {24'b0, anode_n}, 32'hFF);
    chk("rst_sel", {29'b0, sel}, 0);
    chk("rst_Y", {28'b0, Y}, 0);
    chk("rst_pending", {31'b0, pending}, 0);
    chk("rst_fdone", {31'b0, frame_done}, 0);
    reset = 1'b0;
    kk = 0;

    // 1: blank scan out of reset
    check_range(40, 32'h0, 8'h00);

    // 2: basic scan after first load
    do_load(32'h76543210, 8'hFF);
    chk("pend_set", {31'b0, pending}, 1);
    check_range(63, 32'h0, 8'h00);
    check_range(64, 32'h76543210, 8'hFF);
    chk("pend_clr", {31'b0, pending}, 0);
    check_range(110, 32'h76543210, 8'hFF);

    // 3: mid-frame load is held until the wrap
    do_load(32'h89ABCDEF, 8'hFF);
    chk("db_pend", {31'b0, pending}, 1);
    check_range(127, 32'h76543210, 8'hFF);
    chk("db_pend_hold", {31'b0, pending}, 1);
    check_range(128, 32'h89ABCDEF, 8'hFF);
    chk("db_pend_clr", {31'b0, pending}, 0);
    check_range(159, 32'h89ABCDEF, 8'hFF);

    // 4a: load on the wrap tick applies at once
    do_load(32'h13572468, 8'hFF);
    chk("wrap_load_pend", {31'b0, pending}, 0);
    check_range(195, 32'h13572468, 8'hFF);

    // 4b: two loads in one frame, last wins
    do_load(32'h11111111, 8'hFF);
    chk("two_load_pend1", {31'b0, pending}, 1);
    check_range(199, 32'h13572468, 8'hFF);
    do_load(32'h2468ACE0, 8'hFF);
    chk("two_load_pend2", {31'b0, pending}, 1);
    check_range(223, 32'h13572468, 8'hFF);
    check_range(255, 32'h2468ACE0, 8'hFF);
    chk("two_load_clr", {31'b0, pending}, 0);

    // 5: enable mask and optional leading-zero blanking
    do_load(32'h00000120, 8'h0F);
    check_range(300, 32'h00000120, lz_en);

    // 6: async reset mid-frame with data pending
    do_load(32'h55555555, 8'hFF);
    check_range(309, 32'h00000120, lz_en);
    chk("pre_rst_sel", {29'b0, sel}, 5);
    chk("pre_rst_pend", {31'b0, pending}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_anode", {24'b0, anode_n}, 32'hFF);
    chk("arst_sel", {29'b0, sel}, 0);
    chk("arst_pend", {31'b0, pending}, 0);
    chk("arst_Y", {28'b0, Y}, 0);
    @(negedge clk);
    reset = 1'b0;
    kk = 0;
    check_range(36, 32'h0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Parametrised, time-multiplexed digit scanner for the seven-segment display path. It holds NUM_DIGITS values of DATA_W bits each and cycles through them at a programmable refresh rate. For each digit it presents the selected value to the hex-to-seven-segment decoder together with an active-low anode strobe. New display data is double-buffered and only takes effect at a frame boundary, so a write never produces a torn frame.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16)
- DATA_W, 4, bits per digit value
- REFRESH_DIV, 100000, clk cycles each digit stays selected (>= 2); 1 kHz per digit at 100 MHz

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  NUM_DIGITS*DATA_W  digit values; digit i = data_in[i*DATA_W +: DATA_W]
- digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit blanked
- load  input  1  one-cycle strobe; captures data_in and digit_en into the pending buffer
- pending  output  1  high while captured data awaits the next frame boundary
- Y  output  DATA_W  registered value of the currently selected digit, to the decoder
- sel  output  clog2(NUM_DIGITS)  index of the currently selected digit
- anode_n  output  NUM_DIGITS  active-low one-hot digit strobe; all ones = all off
- frame_done  output  1  one-cycle pulse when sel wraps from NUM_DIGITS-1 to 0

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. The cycle with count = REFRESH_DIV-1 is the "tick".
- On a tick, sel advances by one. sel wraps from NUM_DIGITS-1 to 0, and that tick is the "wrap tick".
- Two register banks:
  - pending bank: {data, en}
  - active bank: {data, en}
- load = 1: data_in and digit_en are written to the pending bank and pending is set to 1. A later load before the boundary overwrites the pending bank (last write wins).
- Wrap tick with pending = 1: pending bank is copied to active bank and pending is cleared.
- Wrap tick with load = 1 in the same cycle: data_in and digit_en go directly into the active bank, and pending ends at 0.
- Y = active data of the selected digit. Y is not masked by enable.
- anode_n bit sel is 0 only when active en[sel] = 1 (and the digit is not blanked per Configuration). All other bits are 1.
- Dead time: in the cycle after every tick, anode_n is forced to all ones. This suppresses ghosting during the digit change.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Pending data is discarded.

## Timing
Reset values:
- prescaler, sel, Y: 0
- anode_n: all ones
- frame_done, pending: 0
- both banks: data 0, en 0

Cycle-level behaviour:
- sel is registered and changes on the tick edge.
- Y and anode_n are registered from the new sel and are valid one cycle after sel changes. That cycle is the dead-time cycle, so anode_n becomes all ones there; the digit strobe asserts one cycle after that.
- frame_done is high for exactly one cycle, coincident with sel = 0 after a wrap tick.
- Digit dwell is REFRESH_DIV cycles, of which REFRESH_DIV-1 have the strobe lit. Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-display latency is at most one frame plus two cycles.

## Configuration
- Macro: DIGIT_SCAN_LEADING_ZERO_BLANK_EN
- Defined: leading-zero blanking is enabled.
  - Digit i > 0 is blanked (strobe suppressed) when the active data of digit i and of every higher digit is 0.
  - Digit 0 is never blanked by this rule.
  - This rule combines with the en mask by AND.
- Undefined: only the en mask controls blanking, and the zero-detect logic is absent.

## Test plan
Bench setup: NUM_DIGITS = 8, DATA_W = 4, REFRESH_DIV = 4.

1. Reset scan:
   - Stimulus: hold reset 3 cycles, then release with no load.
   - Required: anode_n = 8'hFF throughout; sel steps 0..7 every 4 cycles; frame_done pulses every 32 cycles.
2. Basic scan:
   - Stimulus: load data_in = 32'h76543210, digit_en = 8'hFF.
   - Required: after the next wrap, Y equals sel each dwell; anode_n = ~(1 << sel) for 3 of every 4 cycles and 8'hFF on the dead-time cycle.
3. Double buffering:
   - Stimulus: with 32'h76543210 active, load 32'h89ABCDEF mid-frame.
   - Required: pending = 1; old values are shown until the wrap; new values are shown from sel = 0 onward; pending = 0 after the wrap.
4. Collision:
   - Stimulus: assert load exactly on the wrap tick; also issue two loads in one frame.
   - Required: a load on the wrap tick applies immediately with pending = 0; with two loads in one frame, only the second value is displayed.
5. Masking and blanking:
   - Stimulus: digit_en = 8'h0F, data 32'h00000120.
   - Required: digits 4..7 are never strobed.
   - With DIGIT_SCAN_LEADING_ZERO_BLANK_EN defined, digit 3 is also unlit while digits 0..2 are lit.
6. Async reset mid-frame:
   - Stimulus: assert reset while sel = 5 with pending = 1.
   - Required: in the same cycle, anode_n = 8'hFF, sel = 0, pending = 0, and Y = 0.
